full_hash_des_core: RTL and testbench
=====================================

FULL_HASH_DES_CORE -- requirements
Module: full_hash_des_core

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, meaning digest width in 4-bit nibbles; legal range 4..16.
REQ-002 SHALL have parameter ROUNDS, default 32, meaning compression rounds per absorbed byte; legal range 1..64.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port msg_valid  input  1  msg_data/msg_last valid.
REQ-006 SHALL have port msg_ready  output  1  core can accept a byte this cycle.
REQ-007 SHALL have port msg_data  input  8  message byte.
REQ-008 SHALL have port msg_last  input  1  byte is the final byte of the message.
REQ-009 SHALL have port digest  output  4*NIBBLES  hash result, H[NIBBLES-1] in the MSBs.
REQ-010 SHALL have port digest_valid  output  1  one-cycle pulse, digest just updated.

Function
REQ-011 SHALL hold state H[0..NIBBLES-1] (4 bits each); init H[i] = INIT[i mod 8] XOR (i div 8); INIT = 4,B,7,1,D,F,0,3.
REQ-012 SHALL instantiate the existing S_Box module (6-bit in, 4-bit out), one instance per nibble.
REQ-013 SHALL derive per-byte S-box key K6 = {M[3:2]^M[1:0], M[7:4]} from the current byte M.
REQ-014 SHALL per round, all i in parallel from old values: H'[i] = rotl4(H[(i+1) mod NIBBLES] XOR S(K6 XOR {H[i], r[1:0]}), i mod 4); r = round index 0..ROUNDS-1.
REQ-015 SHALL perform exactly one round per clk cycle.
REQ-016 SHALL implement FSM states IDLE, ABSORB, FINAL, DONE.
REQ-017 SHALL in IDLE drive msg_ready=1; on msg_valid&&msg_ready latch byte and msg_last, increment the 64-bit byte counter, go to ABSORB.
REQ-018 SHALL on a byte accepted in IDLE while the previous message is complete first reload H to init values (new message start).
REQ-019 SHALL in ABSORB run ROUNDS rounds; then go to IDLE if latched msg_last=0, else to FINAL.
REQ-020 SHALL in FINAL absorb the 8 bytes of the byte counter, LSB byte first, ROUNDS rounds each, same round function.
REQ-021 SHALL after the last FINAL round go to DONE; in DONE register digest from H, pulse digest_valid for 1 cycle, clear counter, go to IDLE.
REQ-022 SHALL drive msg_ready=0 in ABSORB, FINAL and DONE; msg_valid there SHALL be ignored with no state change.
REQ-023 SHALL hold digest stable between digest_valid pulses; H updates SHALL NOT be visible on digest.
REQ-024 SHALL have latency: non-last byte accepted at cycle t -> msg_ready high again at t+ROUNDS+1.
REQ-025 SHALL have latency: last byte accepted at cycle t -> digest_valid at t+9*ROUNDS+1, msg_ready high at t+9*ROUNDS+2.
REQ-026 SHALL wrap the byte counter modulo 2^64 silently.
REQ-027 SHALL treat msg_data/msg_last as don't-care when msg_valid=0.
REQ-028 SHALL be free of combinational paths from msg_valid to msg_ready.

Reset
REQ-029 SHALL on rst=1 at a clk edge set FSM to IDLE, H to init values, counter 0, round index 0.
REQ-030 SHALL on reset drive digest=0, digest_valid=0, msg_ready=1 from the next cycle.
REQ-031 SHALL on reset mid-ABSORB/FINAL abandon the message with no digest_valid pulse.
REQ-032 SHALL give rst priority over msg_valid in the same cycle.

Verification
REQ-033 SHALL cover reset: rst high 2 cycles -> digest=0, digest_valid=0, msg_ready=1.
REQ-034 SHALL cover single byte 0x00 with msg_last=1, ROUNDS=32: accepted at t -> digest_valid exactly at t+289, msg_ready at t+290.
REQ-035 SHALL cover 3-byte message 0x61,0x62,0x63 with back-to-back msg_valid: msg_ready low 32 cycles after each byte; digest equals golden C model.
REQ-036 SHALL cover msg_valid held high while busy: no extra byte absorbed; counter=3 in FINAL for the 3-byte case.
REQ-037 SHALL cover rst asserted 10 cycles into FINAL: no digest_valid; next 1-byte message produces the same digest as REQ-034.
REQ-038 SHALL cover parameter sweep NIBBLES=4,8,16 and ROUNDS=1,32: random messages of 1..300 bytes match the golden model.

Source files
------------

// File: rtl/full_hash_des_core.sv
// Nibble-wide iterative hash built around DES S-boxes: one round per clock,
// each absorbed byte (message bytes, then the 64-bit length) gets ROUNDS rounds.

module S_Box (
    input  logic [5:0] sbox_in,
    output logic [3:0] sbox_out
);
    // DES S1, row = {b5,b0}, column = b4..b1
    localparam logic [3:0] S1 [64] = '{
        4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,
        4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
        4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,
        4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
        4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11,
        4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
        4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,
        4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13
    };

    assign sbox_out = S1[{sbox_in[5], sbox_in[0], sbox_in[4:1]}];
endmodule

// state  | meaning
// IDLE   | waiting for a message byte (msg_ready high)
// ABSORB | ROUNDS rounds on the latched message byte
// FINAL  | ROUNDS rounds on each of the 8 length bytes, LSB first
// DONE   | digest published, length counter cleared
module full_hash_des_core #(
    parameter int NIBBLES = 8,
    parameter int ROUNDS  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    input  logic [7:0]             msg_data,
    input  logic                   msg_last,
    output logic [4*NIBBLES-1:0]   digest,
    output logic                   digest_valid
);
    typedef enum logic [1:0] {IDLE, ABSORB, FINAL, DONE} state_t;

    function automatic logic [4*NIBBLES-1:0] init_state();
        logic [31:0]           tab;
        logic [4*NIBBLES-1:0]  res;
        tab = 32'h30FD_17B4;
        res = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            res[4*i +: 4] = tab[4*(i%8) +: 4] ^ 4'(i/8);
        end
        return res;
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input int s);
        case (s)
            0:       rotl4 = x;
            1:       rotl4 = {x[2:0], x[3]};
            2:       rotl4 = {x[1:0], x[3:2]};
            default: rotl4 = {x[0], x[3:1]};
        endcase
    endfunction

    localparam logic [4*NIBBLES-1:0] H_INIT = init_state();

    state_t                 state_q, state_d;
    logic [4*NIBBLES-1:0]   h_q, h_next;
    logic [7:0]             byte_q;
    logic                   last_q;
    logic [63:0]            cnt_q;
    logic [5:0]             round_q;
    logic [2:0]             bidx_q;
    logic                   msg_done_q;
    logic                   accept, round_en, round_last;
    logic [7:0]             cur_byte;
    logic [5:0]             k6;

    assign round_last = (round_q == 6'(ROUNDS-1));
    assign cur_byte   = (state_q == FINAL) ? cnt_q[{bidx_q, 3'b000} +: 8] : byte_q;
    assign k6         = {cur_byte[3:2] ^ cur_byte[1:0], cur_byte[7:4]};

    for (genvar i = 0; i < NIBBLES; i++) begin : gen_nib
        localparam int NXT = (i + 1) % NIBBLES;
        logic [5:0] sb_in;
        logic [3:0] sb_out;
        logic [3:0] mix;

        assign sb_in = k6 ^ {h_q[4*i +: 4], round_q[1:0]};
        S_Box u_sbox (.sbox_in(sb_in), .sbox_out(sb_out));
        assign mix = h_q[4*NXT +: 4] ^ sb_out;
        assign h_next[4*i +: 4] = rotl4(mix, i % 4);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // msg_ready depends on state only, never on msg_valid
    always_comb begin
        state_d   = state_q;
        msg_ready = 1'b0;
        accept    = 1'b0;
        round_en  = 1'b0;
        case (state_q)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    accept  = 1'b1;
                    state_d = ABSORB;
                end
            end
            ABSORB: begin
                round_en = 1'b1;
                if (round_last) state_d = last_q ? FINAL : IDLE;
            end
            FINAL: begin
                round_en = 1'b1;
                if (round_last && bidx_q == 3'd7) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q          <= H_INIT;
            byte_q       <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            round_q      <= '0;
            bidx_q       <= '0;
            msg_done_q   <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            if (accept) begin
                byte_q <= msg_data;
                last_q <= msg_last;
                cnt_q  <= cnt_q + 64'd1;
                // first byte of a new message starts from the initial state
                if (msg_done_q) begin
                    h_q        <= H_INIT;
                    msg_done_q <= 1'b0;
                end
            end
            if (round_en) begin
                h_q <= h_next;
                if (round_last) begin
                    round_q <= '0;
                    if (state_q == FINAL) bidx_q <= bidx_q + 3'd1;
                end else begin
                    round_q <= round_q + 6'd1;
                end
            end
            if (state_q == FINAL && state_d == DONE) begin
                digest       <= h_next;
                digest_valid <= 1'b1;
            end
            if (state_q == DONE) begin
                cnt_q      <= '0;
                msg_done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_full_hash_des_core.sv
// Self-checking bench: three core configurations against an array-based
// reference of the hash, with latency, pulse-width and reset checks.

module tb_full_hash_des_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mv  [3];
    logic [7:0]  md  [3];
    logic        ml  [3];
    logic        rdy [3];
    logic        dv  [3];
    logic [31:0] dg0;
    logic [15:0] dg1;
    logic [63:0] dg2;
    logic [63:0] dg  [3];
    logic [63:0] last_dg [3];

    int checks = 0;
    int errors = 0;

    assign dg[0] = {32'h0, dg0};
    assign dg[1] = {48'h0, dg1};
    assign dg[2] = dg2;

    full_hash_des_core #(.NIBBLES(8), .ROUNDS(32)) dut (
        .clk(clk), .rst(rst), .msg_valid(mv[0]), .msg_ready(rdy[0]), .msg_data(md[0]),
        .msg_last(ml[0]), .digest(dg0), .digest_valid(dv[0]));
    full_hash_des_core #(.NIBBLES(4), .ROUNDS(1)) dut_n4 (
        .clk(clk), .rst(rst), .msg_valid(mv[1]), .msg_ready(rdy[1]), .msg_data(md[1]),
        .msg_last(ml[1]), .digest(dg1), .digest_valid(dv[1]));
    full_hash_des_core #(.NIBBLES(16), .ROUNDS(32)) dut_n16 (
        .clk(clk), .rst(rst), .msg_valid(mv[2]), .msg_ready(rdy[2]), .msg_data(md[2]),
        .msg_last(ml[2]), .digest(dg2), .digest_valid(dv[2]));

    int init_t [8] = '{4, 11, 7, 1, 13, 15, 0, 3};
    int sbox_t [64] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13};

    function automatic int sbox(input int x);
        int row, col;
        row = (((x >> 5) & 1) * 2) + (x & 1);
        col = (x >> 1) & 15;
        return sbox_t[row*16 + col];
    endfunction

    function automatic logic [63:0] model_hash(input logic [7:0] m[$], input int n, input int rounds);
        int               h [16];
        int               hn [16];
        logic [7:0]       stream [$];
        logic [63:0]      cnt;
        logic [63:0]      res;
        stream = m;
        cnt = 64'(m.size());
        for (int k = 0; k < 8; k++) stream.push_back(8'(cnt >> (8*k)));
        for (int i = 0; i < n; i++) h[i] = init_t[i % 8] ^ (i / 8);
        foreach (stream[s]) begin
            int mb, k6;
            mb = int'(stream[s]);
            k6 = ((((mb >> 2) & 3) ^ (mb & 3)) << 4) | ((mb >> 4) & 15);
            for (int r = 0; r < rounds; r++) begin
                for (int i = 0; i < n; i++) begin
                    int t, sh;
                    t  = h[(i + 1) % n] ^ sbox(k6 ^ (((h[i] << 2) | (r & 3)) & 63));
                    sh = i % 4;
                    hn[i] = ((t << sh) | (t >> (4 - sh))) & 15;
                end
                for (int i = 0; i < n; i++) h[i] = hn[i];
            end
        end
        res = '0;
        for (int i = 0; i < n; i++) res = res | (64'(h[i]) << (4*i));
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts on a negedge with the core idle; returns on the negedge after the last accept.
    // msg_valid stays high while the core is busy so ignored bytes would corrupt the digest.
    task automatic send_bytes(input int id, input logic [7:0] m[$], input int rounds, input bit gaps);
        int j;
        for (int b = 0; b < m.size(); b++) begin
            mv[id] = 1'b1;
            md[id] = m[b];
            ml[id] = (b == m.size() - 1);
            if (b == 0) check("digest_hold", dg[id], last_dg[id]);
            @(posedge clk);
            @(negedge clk);
            j = 1;
            if (b == m.size() - 1) begin
                mv[id] = 1'b0;
                md[id] = 8'($urandom);
                ml[id] = 1'($urandom);
            end else begin
                md[id] = m[b+1];
                ml[id] = (b + 1 == m.size() - 1);
                while (!rdy[id] && j < rounds + 10) begin
                    @(negedge clk);
                    j++;
                end
                check("ready_latency", 64'(j), 64'(rounds + 1));
                if (gaps && $urandom_range(0, 1) == 1) begin
                    mv[id] = 1'b0;
                    md[id] = 8'($urandom);
                    ml[id] = 1'($urandom);
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_digest(input int id, input logic [63:0] exp, input int rounds);
        int j;
        bit stable;
        j = 1;
        stable = 1'b1;
        while (!dv[id] && j < 9*rounds + 20) begin
            if (dg[id] !== last_dg[id]) stable = 1'b0;
            @(negedge clk);
            j++;
        end
        check("digest_stable", 64'(stable), 64'd1);
        check("digest_valid_seen", 64'(dv[id]), 64'd1);
        check("digest_latency", 64'(j), 64'(9*rounds + 1));
        check("digest_value", dg[id], exp);
        @(negedge clk);
        check("digest_valid_pulse", 64'(dv[id]), 64'd0);
        check("ready_after_done", 64'(rdy[id]), 64'd1);
        check("digest_after_pulse", dg[id], exp);
        last_dg[id] = exp;
    endtask

    task automatic run_msg(input int id, input logic [7:0] m[$], input int n, input int rounds, input bit gaps);
        logic [63:0] exp;
        exp = model_hash(m, n, rounds);
        send_bytes(id, m, rounds, gaps);
        wait_digest(id, exp, rounds);
    endtask

    task automatic rand_msg(output logic [7:0] m[$]);
        int len;
        m.delete();
        len = $urandom_range(1, 300);
        for (int k = 0; k < len; k++) m.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] m [$];
        logic [7:0] zero_msg [$];
        logic [7:0] abc_msg [$];
        bit         seen;

        zero_msg = '{8'h00};
        abc_msg  = '{8'h61, 8'h62, 8'h63};
        rst = 1'b1;
        for (int id = 0; id < 3; id++) begin
            mv[id] = 1'b0;
            md[id] = 8'h00;
            ml[id] = 1'b0;
            last_dg[id] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            check("reset_digest", dg[id], 64'h0);
            check("reset_digest_valid", 64'(dv[id]), 64'd0);
            check("reset_ready", 64'(rdy[id]), 64'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        run_msg(0, zero_msg, 8, 32, 1'b0);
        run_msg(0, abc_msg, 8, 32, 1'b0);

        // reset ten cycles into the length phase of "abc"
        send_bytes(0, abc_msg, 32, 1'b0);
        seen = 1'b0;
        for (int j = 1; j < 43; j++) begin
            if (dv[0]) seen = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) begin
            if (dv[0]) seen = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int id = 0; id < 3; id++) last_dg[id] = '0;
        check("post_reset_digest", dg[0], 64'h0);
        check("post_reset_ready", 64'(rdy[0]), 64'd1);
        repeat (300) begin
            if (dv[0]) seen = 1'b1;
            @(negedge clk);
        end
        check("abandoned_no_pulse", 64'(seen), 64'd0);
        run_msg(0, zero_msg, 8, 32, 1'b0);

        for (int k = 0; k < 2; k++) begin
            rand_msg(m);
            run_msg(0, m, 8, 32, 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            rand_msg(m);
            run_msg(1, m, 4, 1, 1'b1);
        end
        run_msg(1, abc_msg, 4, 1, 1'b0);
        run_msg(2, abc_msg, 16, 32, 1'b0);
        rand_msg(m);
        run_msg(2, m, 16, 32, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
